// File: rtl/uart_tx.sv
// UART transmitter: start bit, D_W data bits LSB-first, optional parity, 1-2 stop bits.
// One bit period is B_TICK pulses of the shared baud tick; byte input is valid/ready.
module uart_tx #(
  parameter int D_W       = 8,
  parameter int B_TICK    = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [D_W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  localparam int TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
  localparam int NW = $clog2(D_W + 1);
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(B_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D_W - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [NW-1:0]  nbits_q, nbits_d;
  logic [SW-1:0]  stop_cnt_q, stop_cnt_d;
  logic [D_W-1:0] shift_q, shift_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic           bit_end;

  assign bit_end  = tick && (tick_cnt_q == T_LAST);
  assign in_ready = rst && (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    nbits_d    = nbits_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    // tick counter only runs inside a frame
    if (state_q != S_IDLE && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d    = in_data;
          par_d      = (PARITY == 2) ? ~(^in_data) : ^in_data;
          tick_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          nbits_d = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          nbits_d = nbits_q + 1'b1;
          if (nbits_q == N_LAST) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = '0;
              state_d    = S_STOP;
            end
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          tx_d       = 1'b1;
          stop_cnt_d = '0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == S_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      nbits_q    <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      nbits_q    <= nbits_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four lanes (no parity, even, odd, two stop bits) share one tick.
// Accepted bytes are queued; a monitor rebuilds each frame from tick counts and compares.
module tb_uart_tx;

  localparam int NL = 4;
  localparam int BT = 16;

  logic          clk;
  logic          tick;
  logic [NL-1:0] rst_n;
  logic [NL-1:0] in_valid;
  logic [NL-1:0] in_ready;
  logic [NL-1:0] tx;
  logic [NL-1:0] busy;
  logic [NL-1:0] tx_done;
  logic [7:0]    in_data [NL];

  logic [7:0] sb_q [NL][$];
  int         to_cnt [NL];
  bit         gto;

  int compared;
  int mismatched;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    uart_tx #(
      .D_W      (8),
      .B_TICK   (BT),
      .PARITY   ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst_n[g]),
      .tick    (tick),
      .in_data (in_data[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .tx      (tx[g]),
      .busy    (busy[g]),
      .tx_done (tx_done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick every 4 clk, with occasional 100-clk silences
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) begin
        @(posedge clk);
        #1 tick = 1'b0;
      end
      @(posedge clk);
      #1 tick = 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk);
        #1 tick = 1'b0;
        repeat (100) @(posedge clk);
      end
    end
  end

  function automatic int lane_par(int l);
    return (l == 1) ? 1 : ((l == 2) ? 2 : 0);
  endfunction

  function automatic int lane_stop(int l);
    return (l == 3) ? 2 : 1;
  endfunction

  function automatic int frame_ticks(int l);
    return BT * (1 + 8 + ((lane_par(l) != 0) ? 1 : 0) + lane_stop(l));
  endfunction

  // Line level expected after k ticks into a frame
  function automatic logic line_at(int l, logic [7:0] d, int k);
    int b;
    int ones;
    b = k / BT;
    ones = $countones(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (lane_par(l) != 0 && b == 9) begin
      if (lane_par(l) == 1) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic chk(string nm, int l, logic act, logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s lane%0d: got %0b expected %0b at %0t",
                 nm, l, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  bit         in_frame [NL];
  bit         pending  [NL];
  int         k        [NL];
  int         seen_to  [NL];
  logic [7:0] cur      [NL];
  bit         gto_seen;

  initial begin
    for (int l = 0; l < NL; l++) begin
      in_frame[l] = 0;
      pending[l]  = 0;
      k[l]        = 0;
      seen_to[l]  = 0;
      cur[l]      = '0;
    end
    gto_seen = 0;
    forever begin
      @(negedge clk);
      if (gto && !gto_seen) begin
        gto_seen = 1;
        chk("drain_timeout", 0, 1'b1, 1'b0);
      end
      for (int l = 0; l < NL; l++) begin
        if (seen_to[l] != to_cnt[l]) begin
          seen_to[l] = to_cnt[l];
          chk("accept_timeout", l, 1'b1, 1'b0);
        end
        if (!rst_n[l]) begin
          chk("rst_tx", l, tx[l], 1'b1);
          chk("rst_busy", l, busy[l], 1'b0);
          chk("rst_done", l, tx_done[l], 1'b0);
          chk("rst_ready", l, in_ready[l], 1'b0);
          if (pending[l] && sb_q[l].size() > 0) void'(sb_q[l].pop_front());
          in_frame[l] = 0;
          pending[l]  = 0;
        end else begin
          if (pending[l]) begin
            if (sb_q[l].size() > 0) cur[l] = sb_q[l].pop_front();
            else chk("queue_empty", l, 1'b1, 1'b0);
            in_frame[l] = 1;
            pending[l]  = 0;
            k[l]        = 0;
          end
          if (in_frame[l]) begin
            if (k[l] < frame_ticks(l)) begin
              chk("tx_bit", l, tx[l], line_at(l, cur[l], k[l]));
              chk("busy", l, busy[l], 1'b1);
              chk("ready_busy", l, in_ready[l], 1'b0);
              chk("done_early", l, tx_done[l], 1'b0);
              if (tick) k[l]++;
            end else begin
              chk("tx_done", l, tx_done[l], 1'b1);
              chk("busy_end", l, busy[l], 1'b0);
              chk("tx_end", l, tx[l], 1'b1);
              in_frame[l] = 0;
            end
          end else begin
            chk("idle_tx", l, tx[l], 1'b1);
            chk("idle_busy", l, busy[l], 1'b0);
            chk("idle_done", l, tx_done[l], 1'b0);
            chk("idle_ready", l, in_ready[l], 1'b1);
          end
          if (in_valid[l] && in_ready[l]) pending[l] = 1;
        end
      end
    end
  end

  task automatic send(int l, logic [7:0] b);
    bit ok;
    ok = 0;
    in_data[l]  = b;
    in_valid[l] = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (in_ready[l]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) to_cnt[l]++;
    @(posedge clk);
    #1;
    if (ok) sb_q[l].push_back(b);
    in_valid[l] = 1'b0;
    in_data[l]  = 8'($urandom);
  endtask

  task automatic reset_mid_frame(int l);
    int n;
    n = 0;
    send(l, 8'h5A);
    for (int i = 0; i < 6000 && n < 70; i++) begin
      @(negedge clk);
      if (tick) n++;
    end
    @(posedge clk);
    #1 rst_n[l] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n[l] = 1'b1;
  endtask

  task automatic lane_seq(int l);
    if (l == 0) begin
      send(l, 8'hA5);
      reset_mid_frame(l);
      send(l, 8'h3C);
      send(l, 8'h11);
      send(l, 8'h22);
    end else begin
      send(l, (l == 3) ? 8'h00 : 8'h07);
    end
    repeat (6) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1 send(l, 8'($urandom));
    end
  endtask

  initial begin
    bit drained;
    gto        = 0;
    compared   = 0;
    mismatched = 0;
    rst_n      = '1;
    in_valid   = '0;
    for (int l = 0; l < NL; l++) begin
      in_data[l] = '0;
      to_cnt[l]  = 0;
    end
    #1 rst_n = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = '1;
    fork
      lane_seq(0);
      lane_seq(1);
      lane_seq(2);
      lane_seq(3);
    join
    drained = 0;
    for (int i = 0; i < 20000 && !drained; i++) begin
      @(negedge clk);
      drained = 1;
      for (int l = 0; l < NL; l++)
        if (in_frame[l] || pending[l]) drained = 0;
    end
    if (!drained) gto = 1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
